// File: rtl/e_muldiv.sv
// e_muldiv -- iterative-latency multiply/divide unit with architectural HI/LO.
//
// Purpose:
//   Accepts one mult/multu/div/divu/mthi/mtlo request from the E stage when
//   idle. Multiplies occupy 5 busy cycles and divides 10. The result is
//   written into HI/LO on the edge that returns the unit to idle.
//   mthi/mtlo write immediately and raise no busy cycle.
//
// Ports:
//   clk     in   1  single clock, rising edge
//   reset   in   1  synchronous, active-high
//   start   in   1  request strobe from E stage
//   op      in   3  0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,7 none
//   rs_val  in  32  dividend / multiplicand / mthi,mtlo source
//   rt_val  in  32  divisor / multiplier
//   flush   in   1  abort in-flight op (only with MULDIV_FLUSH_EN)
//   busy    out  1  registered, high while a mult/div is in flight
//   hi      out 32  HI register
//   lo      out 32  LO register
//
// Configuration macro: MULDIV_FLUSH_EN adds the flush port and abort logic.
module e_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
`ifdef MULDIV_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        abort;

`ifdef MULDIV_FLUSH_EN
    assign abort = flush;
`else
    assign abort = 1'b0;
`endif

    // Product: one 64x64 multiplier; extending operands by sign or zero
    // selects signed or unsigned, and the low 64 bits are exact either way.
    logic        mul_signed;
    logic [63:0] ext_a, ext_b, product;

    assign mul_signed = (op_q == OP_MULT);
    assign ext_a      = {(mul_signed ? {32{a_q[31]}} : 32'd0), a_q};
    assign ext_b      = {(mul_signed ? {32{b_q[31]}} : 32'd0), b_q};
    assign product    = ext_a * ext_b;

    // Signed divide runs on magnitudes and fixes signs afterwards. This keeps
    // 0x80000000 / -1 well defined: magnitude 0x80000000 negates to itself.
    logic        div_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag, uquot, urem, quot, rem;

    assign div_signed = (op_q == OP_DIV);
    assign a_neg      = div_signed & a_q[31];
    assign b_neg      = div_signed & b_q[31];
    assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag      = b_neg ? (32'd0 - b_q) : b_q;
    assign uquot      = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign urem       = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign quot       = (a_neg ^ b_neg) ? (32'd0 - uquot) : uquot;
    assign rem        = a_neg ? (32'd0 - urem) : urem;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (abort) begin
            // Abort wins over start and completion; HI/LO keep their values.
            state_d = IDLE;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                state_d = BUSY;
                                cnt_d   = 4'd5;
                                op_d    = op;
                                a_d     = rs_val;
                                b_d     = rt_val;
                            end
                            OP_DIV, OP_DIVU: begin
                                state_d = BUSY;
                                cnt_d   = 4'd10;
                                op_d    = op;
                                a_d     = rs_val;
                                b_d     = rt_val;
                            end
                            OP_MTHI: hi_d = rs_val;
                            OP_MTLO: lo_d = rs_val;
                            default: ;
                        endcase
                    end
                end
                BUSY: begin
                    // start is ignored here, including in the final cycle.
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = IDLE;
                        if (op_q == OP_MULT || op_q == OP_MULTU) begin
                            hi_d = product[63:32];
                            lo_d = product[31:0];
                        end else if (b_q != 32'd0) begin
                            // Divide by zero burns the cycles but writes nothing.
                            hi_d = rem;
                            lo_d = quot;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q == BUSY);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_e_muldiv.sv
// tb_e_muldiv -- randomized self-checking bench for e_muldiv.
// Inputs change and outputs are sampled on the falling clock edge.
// A reference model written with 64-bit integer arithmetic predicts HI/LO
// and the busy length of every request.
module tb_e_muldiv;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs_val, rt_val;
    logic        busy;
    logic [31:0] hi, lo;
`ifdef MULDIV_FLUSH_EN
    logic        flush;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_hi, exp_lo;

    e_muldiv dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .rs_val (rs_val),
        .rt_val (rt_val),
`ifdef MULDIV_FLUSH_EN
        .flush  (flush),
`endif
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Reference model: returns expected busy length, updates exp_hi/exp_lo.
    function automatic int model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          ia, ib;
        longint      sa, sb, sq, sr;
        logic [63:0] p;
        ia = a; ib = b; sa = ia; sb = ib;
        case (o)
            3'd1: begin p = sa * sb; exp_hi = p[63:32]; exp_lo = p[31:0]; return 5; end
            3'd2: begin p = {32'd0, a} * {32'd0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; return 5; end
            3'd3: begin
                if (b != 0) begin
                    sq = sa / sb; sr = sa % sb;
                    p = sq; exp_lo = p[31:0];
                    p = sr; exp_hi = p[31:0];
                end
                return 10;
            end
            3'd4: begin
                if (b != 0) begin exp_lo = a / b; exp_hi = a % b; end
                return 10;
            end
            3'd5: begin exp_hi = a; return 0; end
            3'd6: begin exp_lo = a; return 0; end
            default: return 0;
        endcase
    endfunction

    // Issue at a falling edge; returns at the falling edge where busy is 0.
    // While busy, operands are scrambled and stray mtlo requests injected.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int          ncyc, n;
        logic [31:0] old_hi, old_lo;
        old_hi = exp_hi; old_lo = exp_lo;
        ncyc = model(o, a, b);
        start = 1'b1; op = o; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && n < 20) begin
            n++;
            check("hold_hi", hi, old_hi);
            check("hold_lo", lo, old_lo);
            rs_val = $urandom; rt_val = $urandom;
            start  = ($urandom_range(0, 1) == 1) || (n == ncyc);
            op     = 3'd6;
            @(negedge clk);
        end
        start = 1'b0;
        check("busy_len", n, ncyc);
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
        $display("op=%0d rs=%08h rt=%08h busy=%0d hi=%08h lo=%08h", o, a, b, n, hi, lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int          k;
        reset = 1'b1; start = 1'b0; op = 3'd0; rs_val = 32'd0; rt_val = 32'd0;
`ifdef MULDIV_FLUSH_EN
        flush = 1'b0;
`endif
        exp_hi = 32'd0; exp_lo = 32'd0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);

        // Directed cases, issued back to back (first idle cycle accepted).
        run_op(3'd1, 32'hFFFFFFFE, 32'd3);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_op(3'd3, 32'hFFFFFFF9, 32'd2);
        run_op(3'd4, 32'd7, 32'd0);
        run_op(3'd3, 32'h80000000, 32'hFFFFFFFF);
        run_op(3'd5, 32'h12345678, 32'd0);
        run_op(3'd6, 32'h9ABCDEF0, 32'd0);
        run_op(3'd0, 32'h11111111, 32'd1);
        run_op(3'd7, 32'h22222222, 32'd1);
        run_op(3'd3, 32'd7, 32'hFFFFFFFE);
        run_op(3'd3, 32'd0, 32'd0);

        // Reset at busy cycle 4 of a divide, with a concurrent start.
        start = 1'b1; op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1; start = 1'b1; op = 3'd5; rs_val = 32'hDEADBEEF;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        exp_hi = 32'd0; exp_lo = 32'd0;
        check("rstmid_busy", {31'd0, busy}, 32'd0);
        check("rstmid_hi", hi, 32'd0);
        check("rstmid_lo", lo, 32'd0);
        run_op(3'd1, 32'd6, 32'hFFFFFFF9);

`ifdef MULDIV_FLUSH_EN
        start = 1'b1; op = 3'd1; rs_val = 32'd3; rt_val = 32'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        flush = 1'b1; start = 1'b1; op = 3'd5; rs_val = 32'hCAFEF00D;
        @(negedge clk);
        flush = 1'b0; start = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        check("flush_hi", hi, exp_hi);
        check("flush_lo", lo, exp_lo);
        @(negedge clk);
        check("flush_idle", {31'd0, busy}, 32'd0);
`endif

        // Randomized traffic with some corner operands.
        for (int i = 0; i < 60; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom; rb = $urandom;
            k  = $urandom_range(0, 9);
            if (k == 0) rb = 32'd0;
            if (k == 1) begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
            if (k == 2) rb = 32'($urandom_range(1, 16));
            if (k == 3) rb = -32'($urandom_range(1, 16));
            run_op(ro, ra, rb);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
